// File: rtl/ror_sched_pkg.sv
// rtl/ror_sched_pkg.sv - shared FSM states and rotator pass encodings for ror_sched
package ror_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_R1   = 2'b01;
    localparam logic [1:0] CTRL_R2   = 2'b10;
    localparam logic [1:0] CTRL_R3   = 2'b11;

    localparam int MAX_PASS = 3;

endpackage

// File: rtl/ror.sv
// rtl/ror.sv - combinational N-bit rotate-right by 0..3 selected by ctrl, pass-through when disabled
module ror #(
    parameter int N = 4
) (
    input  logic [N-1:0] bits,
    input  logic [1:0]   ctrl,
    input  logic         en,
    output logic [N-1:0] rot
);

    logic [2*N-1:0] dbl;

    always_comb begin
        dbl = {bits, bits} >> ctrl;
        rot = en ? dbl[N-1:0] : bits;
    end

endmodule

// File: rtl/ror_sched_arb2.sv
// rtl/ror_sched_arb2.sv - 2-way round-robin arbiter, pointer moves to the winner on grant
module ror_sched_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    logic ptr_q;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        if (req_i[0] && req_i[1]) begin
            grant_id_o = ~ptr_q;
        end else begin
            grant_id_o = req_i[1];
        end
        grant_o = 2'b00;
        if (en_i) begin
            grant_o = grant_id_o ? {req_i[1], 1'b0} : {1'b0, req_i[0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (|grant_o) begin
            ptr_q <= grant_id_o;
        end
    end

endmodule

// File: rtl/ror_sched.sv
// rtl/ror_sched.sv - round-robin scheduler sequencing rotate requests through one shared ror
// Optional single-pass mode: ROR_SCHED_FAST_EN
module ror_sched
    import ror_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N-1:0]     req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N-1:0]     req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             rsp_id
);

    state_t           state_q;
    logic [N-1:0]     work_q;
    logic [AMT_W-1:0] rem_q;
    logic             id_q;
    logic             rsp_valid_q;

    logic [1:0]       grant;
    logic             grant_id;
    logic [N-1:0]     acc_data;
    logic [AMT_W-1:0] acc_amt;
    logic [1:0]       pass_ctrl;
    logic [AMT_W-1:0] rem_d;
    logic [N-1:0]     work_d;

    ror_sched_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      ({req1_valid, req0_valid}),
        .en_i       (state_q == ST_IDLE),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    ror #(.N(N)) u_ror (
        .bits (work_q),
        .ctrl (pass_ctrl),
        .en   (state_q == ST_RUN),
        .rot  (work_d)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = work_q;
    assign rsp_id     = id_q;

    always_comb begin
        acc_data = grant_id ? req1_data : req0_data;
`ifdef ROR_SCHED_FAST_EN
        acc_amt  = AMT_W'(grant_id ? req1_amt[1:0] : req0_amt[1:0]);
`else
        acc_amt  = grant_id ? req1_amt : req0_amt;
`endif
        pass_ctrl = (rem_q >= AMT_W'(MAX_PASS)) ? CTRL_R3 : rem_q[1:0];
        rem_d     = rem_q - AMT_W'(pass_ctrl);
    end

    // A zero amount still takes one pass (ctrl 00) so latency is never below one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        work_q  <= acc_data;
                        rem_q   <= acc_amt;
                        id_q    <= grant_id;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ror_sched.sv
// tb/tb_ror_sched.sv - randomized self-checking bench for ror_sched against a rotate/arbitration model
module tb_ror_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_data, req0_amt, req1_data, req1_amt;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_ptr;

    always #5 clk = ~clk;

    ror_sched #(.N(4), .AMT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    function automatic logic [3:0] model_rot(input logic [3:0] d, input int amt);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = d[(i + amt) % 4];
        return r;
    endfunction

    function automatic int model_passes(input int amt);
`ifdef ROR_SCHED_FAST_EN
        return 1;
`else
        return (amt == 0) ? 1 : (amt + 2) / 3;
`endif
    endfunction

    function automatic bit model_winner(input bit v0, input bit v1, input bit ptr);
        if (v0 && v1) return ~ptr;
        return v1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req0_amt = '0; req1_data = '0; req1_amt = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 1'b1;
    endtask

    task automatic wait_rsp(input string tag, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (n >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: rsp_valid never rose within 20 cycles", tag);
        end
    endtask

    task automatic run_one(input bit id, input logic [3:0] d, input int amt, input string tag);
        int n;
        logic [3:0] exp_d;
        exp_d = model_rot(d, amt);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = 4'(amt);
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = 4'(amt);
        end
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL %s ready: got %b expected %b", tag, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        model_ptr = id;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(tag, n);
        n_checks++;
        if (n !== model_passes(amt)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", tag, n, model_passes(amt));
        end
        n_checks++;
        if (rsp_data !== exp_d || rsp_id !== id) begin
            n_fail++;
            $display("FAIL %s result: got data %b id %b expected data %b id %b", tag, rsp_data, rsp_id, exp_d, id);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rsp_drop: got rsp_valid %b expected 0", tag, rsp_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 4'b0000 || rsp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b d%b id%b r%b%b expected v0 d0000 id0 r00",
                     rsp_valid, rsp_data, rsp_id, req1_ready, req0_ready);
        end
    endtask

    task automatic test_directed();
        run_one(1'b0, 4'b1001, 1, "dir_amt1");
        run_one(1'b1, 4'b0001, 7, "dir_amt7");
        run_one(1'b0, 4'b1011, 4, "dir_amt4");
        run_one(1'b0, 4'b1011, 0, "dir_amt0");
        run_one(1'b1, 4'b0110, 15, "dir_amt15");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_one(1'($urandom_range(1)), 4'($urandom_range(15)), int'($urandom_range(15)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d [2];
        logic [3:0] a [2];
        logic [3:0] exp_d;
        bit g;
        int n;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            d[r] = 4'($urandom_range(15));
            a[r] = 4'($urandom_range(15));
        end
        req0_data = d[0]; req0_amt = a[0]; req1_data = d[1]; req1_amt = a[1];
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            g = model_winner(1'b1, 1'b1, model_ptr);
            n_checks++;
            if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01) || g !== k[0]) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: got ready %b expected %b", k, {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
            end
            exp_d = model_rot(d[g], int'(a[g]));
            @(posedge clk);
            model_ptr = g;
            @(negedge clk);
            d[g] = 4'($urandom_range(15));
            a[g] = 4'($urandom_range(15));
            req0_data = d[0]; req0_amt = a[0]; req1_data = d[1]; req1_amt = a[1];
            wait_rsp("b2b", n);
            n_checks++;
            if (rsp_data !== exp_d || rsp_id !== g) begin
                n_fail++;
                $display("FAIL b2b_result%0d: got data %b id %b expected data %b id %b", k, rsp_data, rsp_id, exp_d, g);
            end
            @(posedge clk);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_d;
        logic [3:0] exp_d1;
        int n;
        exp_d  = model_rot(4'b1101, 5);
        exp_d1 = model_rot(4'b0011, 2);
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 4'b1101; req0_amt = 4'd5;
        @(posedge clk);
        model_ptr = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 4'b0011; req1_amt = 4'd2;
        wait_rsp("bp", n);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v%b d%b id%b r%b expected v1 d%b id0 r00",
                         c, rsp_valid, rsp_data, rsp_id, {req1_ready, req0_ready}, exp_d);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_next_accept: got ready %b expected 10", {req1_ready, req0_ready});
        end
        @(posedge clk);
        model_ptr = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp("bp_next", n);
        n_checks++;
        if (rsp_data !== exp_d1 || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_next_result: got data %b id %b expected data %b id 1", rsp_data, rsp_id, exp_d1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit g;
        logic [3:0] exp_d;
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 4'b1010; req1_amt = 4'd15;
        @(posedge clk);
        model_ptr = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 4'b0000 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run: got v%b d%b id%b expected v0 d0000 id0", rsp_valid, rsp_data, rsp_id);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 1'b1;
        req0_valid = 1'b1; req0_data = 4'b0111; req0_amt = 4'd2;
        req1_valid = 1'b1; req1_data = 4'b1000; req1_amt = 4'd3;
        #1;
        g = model_winner(1'b1, 1'b1, model_ptr);
        n_checks++;
        if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rst_tie_grant: got ready %b expected %b", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
        end
        exp_d = g ? model_rot(4'b1000, 3) : model_rot(4'b0111, 2);
        @(posedge clk);
        model_ptr = g;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp("rst_after", n);
        n_checks++;
        if (rsp_data !== exp_d || rsp_id !== g) begin
            n_fail++;
            $display("FAIL rst_after_result: got data %b id %b expected data %b id %b", rsp_data, rsp_id, exp_d, g);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
